ex_bitfield_issue: RTL and testbench

- Single-entry ID/EX pipeline register for the execute-stage bitfield path (EXT/INS and other SPECIAL3 ops).
- Captures the decoded instruction and its register operands from decode, and applies MEM/WB forwarding at capture and on every cycle the entry is held.
- Pre-decodes the bitfield position/size fields.
- Presents registered, stable operands plus valid/ready handshake to the execute datapath directly downstream.

---
 rtl/ex_bitfield_issue.sv | 169 ++++++++++++++++
 tb/tb_ex_bitfield_issue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_bitfield_issue.sv
// ID/EX register for the bitfield execute path: captures decode output, forwards MEM/WB results
// at capture and while stalled, and pre-decodes EXT/INS fields. Define BITFIELD_CHECK_EN for field range check.
module ex_bitfield_issue #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      id_valid,
   output logic                      id_ready,
   input  logic [31:0]               id_inst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
   input  logic [DATA_WIDTH-1:0]     id_rs_data,
   input  logic [DATA_WIDTH-1:0]     id_rt_data,
   input  logic                      mem_we,
   input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
   input  logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic                      wb_we,
   input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0]     wb_wdata,
   output logic                      ex_valid,
   input  logic                      ex_ready,
   output logic [31:0]               ex_inst,
   output logic [DATA_WIDTH-1:0]     ex_op1,
   output logic [DATA_WIDTH-1:0]     ex_op2,
   output logic                      ex_is_ext,
   output logic                      ex_is_ins,
   output logic [4:0]                ex_lsb,
   output logic [4:0]                ex_size_m1,
   output logic                      ex_field_bad
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e                      state_q, state_d;
   logic [31:0]                 inst_q, inst_d;
   logic [DATA_WIDTH-1:0]       op1_q, op1_d, op2_q, op2_d;
   logic [REG_ADDR_WIDTH-1:0]   rs_q, rs_d, rt_q, rt_d;
   logic                        is_ext_q, is_ext_d, is_ins_q, is_ins_d;
   logic [4:0]                  lsb_q, lsb_d, size_m1_q, size_m1_d;
   logic                        capture;
   logic                        dec_is_ext, dec_is_ins;
   logic [4:0]                  dec_size_m1;

   // MEM result is younger than WB, so it wins; r0 is never forwarded.
   function automatic logic [DATA_WIDTH-1:0] fwd(
      input logic [REG_ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0]     regval,
      input logic                      mwe,
      input logic [REG_ADDR_WIDTH-1:0] mwa,
      input logic [DATA_WIDTH-1:0]     mwd,
      input logic                      wwe,
      input logic [REG_ADDR_WIDTH-1:0] wwa,
      input logic [DATA_WIDTH-1:0]     wwd
   );
      logic [DATA_WIDTH-1:0] res;
      res = regval;
      if (addr != '0) begin
         if (mwe && mwa == addr)
            res = mwd;
         else if (wwe && wwa == addr)
            res = wwd;
      end
      return res;
   endfunction

   assign ex_valid = (state_q == FULL);
   assign id_ready = !ex_valid || ex_ready;
   assign capture  = id_valid && id_ready && !flush;

   assign dec_is_ext  = (id_inst[31:26] == 6'b011111) && (id_inst[5:0] == 6'b000000);
   assign dec_is_ins  = (id_inst[31:26] == 6'b011111) && (id_inst[5:0] == 6'b000100);
   assign dec_size_m1 = dec_is_ins ? (id_inst[15:11] - id_inst[10:6]) : id_inst[15:11];

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      is_ext_d  = is_ext_q;
      is_ins_d  = is_ins_q;
      lsb_d     = lsb_q;
      size_m1_d = size_m1_q;
      if (capture) begin
         inst_d    = id_inst;
         rs_d      = id_rs_addr;
         rt_d      = id_rt_addr;
         op1_d     = fwd(id_rs_addr, id_rs_data, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
         op2_d     = fwd(id_rt_addr, id_rt_data, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
         is_ext_d  = dec_is_ext;
         is_ins_d  = dec_is_ins;
         lsb_d     = id_inst[10:6];
         size_m1_d = dec_size_m1;
      end else if (state_q == FULL) begin
         // Snoop late writers so a stalled entry never holds a stale operand.
         op1_d = fwd(rs_q, op1_q, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
         op2_d = fwd(rt_q, op2_q, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
      end
      if (flush)
         state_d = EMPTY;
      else if (capture)
         state_d = FULL;
      else if (state_q == FULL && ex_ready)
         state_d = EMPTY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         inst_q    <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         is_ext_q  <= 1'b0;
         is_ins_q  <= 1'b0;
         lsb_q     <= '0;
         size_m1_q <= '0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         is_ext_q  <= is_ext_d;
         is_ins_q  <= is_ins_d;
         lsb_q     <= lsb_d;
         size_m1_q <= size_m1_d;
      end
   end

`ifdef BITFIELD_CHECK_EN
   logic dec_bad, bad_q;

   // EXT overflows when lsb+size_m1 passes bit 31; INS is bad when msb sits below lsb.
   always_comb begin
      dec_bad = 1'b0;
      if (dec_is_ext)
         dec_bad = ({1'b0, id_inst[10:6]} + {1'b0, id_inst[15:11]}) > 6'd31;
      else if (dec_is_ins)
         dec_bad = id_inst[15:11] < id_inst[10:6];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bad_q <= 1'b0;
      else if (capture)
         bad_q <= dec_bad;
   end

   assign ex_field_bad = bad_q;
`else
   assign ex_field_bad = 1'b0;
`endif

   assign ex_inst    = inst_q;
   assign ex_op1     = op1_q;
   assign ex_op2     = op2_q;
   assign ex_is_ext  = is_ext_q;
   assign ex_is_ins  = is_ins_q;
   assign ex_lsb     = lsb_q;
   assign ex_size_m1 = size_m1_q;

endmodule

// File: tb/tb_ex_bitfield_issue.sv
// Self-checking bench for ex_bitfield_issue: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ex_bitfield_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, id_valid, id_ready;
   logic [31:0] id_inst;
   logic [4:0]  id_rs_addr, id_rt_addr;
   logic [31:0] id_rs_data, id_rt_data;
   logic        mem_we, wb_we;
   logic [4:0]  mem_waddr, wb_waddr;
   logic [31:0] mem_wdata, wb_wdata;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_inst, ex_op1, ex_op2;
   logic        ex_is_ext, ex_is_ins, ex_field_bad;
   logic [4:0]  ex_lsb, ex_size_m1;

   int errorCount = 0;
   int checkCount = 0;
   logic checkEn = 1'b0;

   typedef struct {
      logic        v;
      logic [31:0] inst;
      logic [4:0]  rsA, rtA;
      logic [31:0] rsD, rtD;
      logic        mwe;
      logic [4:0]  mwa;
      logic [31:0] mwd;
      logic        wwe;
      logic [4:0]  wwa;
      logic [31:0] wwd;
      logic        exr;
      logic        fl;
   } stim_t;

   // Model state: one entry (or none) plus the last captured fields.
   logic        mValid;
   logic [31:0] mInst, mOp1, mOp2;
   logic [4:0]  mRs, mRt;
   int          mLsb, mSize;
   logic        mIsExt, mIsIns, mBad;

   ex_bitfield_issue #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst),
      .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_is_ext(ex_is_ext), .ex_is_ins(ex_is_ins),
      .ex_lsb(ex_lsb), .ex_size_m1(ex_size_m1), .ex_field_bad(ex_field_bad)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Newest pending write to a nonzero register wins; otherwise the supplied value stands.
   function automatic logic [31:0] modelFwd(input logic [4:0] a, input logic [31:0] val);
      if (a == 0) return val;
      if (mem_we && mem_waddr == a) return mem_wdata;
      if (wb_we && wb_waddr == a) return wb_wdata;
      return val;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mValid = 0; mInst = 0; mOp1 = 0; mOp2 = 0; mRs = 0; mRt = 0;
         mLsb = 0; mSize = 0; mIsExt = 0; mIsIns = 0; mBad = 0;
      end else begin
         automatic logic accept = id_valid && (!mValid || ex_ready) && !flush;
         automatic int msb = int'(id_inst[15:11]);
         automatic int lsb = int'(id_inst[10:6]);
         if (accept) begin
            mInst  = id_inst;
            mRs    = id_rs_addr;
            mRt    = id_rt_addr;
            mOp1   = modelFwd(id_rs_addr, id_rs_data);
            mOp2   = modelFwd(id_rt_addr, id_rt_data);
            mIsExt = (id_inst[31:26] == 6'd31) && (id_inst[5:0] == 6'd0);
            mIsIns = (id_inst[31:26] == 6'd31) && (id_inst[5:0] == 6'd4);
            mLsb   = lsb;
            mSize  = mIsIns ? (msb - lsb + 32) % 32 : msb;
`ifdef BITFIELD_CHECK_EN
            mBad   = mIsExt ? (lsb + mSize > 31) : (mIsIns ? (msb < lsb) : 1'b0);
`else
            mBad   = 1'b0;
`endif
         end else if (mValid) begin
            mOp1 = modelFwd(mRs, mOp1);
            mOp2 = modelFwd(mRt, mOp2);
         end
         if (flush) mValid = 0;
         else if (accept) mValid = 1;
         else if (ex_ready) mValid = 0;
      end
   end

   // Every cycle outside reset the DUT must match the model.
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("id_ready", 32'(id_ready), 32'(!mValid || ex_ready));
         checkOutput("ex_valid", 32'(ex_valid), 32'(mValid));
         checkOutput("ex_inst", ex_inst, mInst);
         checkOutput("ex_op1", ex_op1, mOp1);
         checkOutput("ex_op2", ex_op2, mOp2);
         checkOutput("ex_is_ext", 32'(ex_is_ext), 32'(mIsExt));
         checkOutput("ex_is_ins", 32'(ex_is_ins), 32'(mIsIns));
         checkOutput("ex_lsb", 32'(ex_lsb), 32'(mLsb));
         checkOutput("ex_size_m1", 32'(ex_size_m1), 32'(mSize));
         checkOutput("ex_field_bad", 32'(ex_field_bad), 32'(mBad));
      end
   end

   function automatic stim_t idleStim();
      stim_t s;
      s.v = 0; s.inst = 0; s.rsA = 0; s.rtA = 0; s.rsD = 0; s.rtD = 0;
      s.mwe = 0; s.mwa = 0; s.mwd = 0; s.wwe = 0; s.wwa = 0; s.wwd = 0;
      s.exr = 1; s.fl = 0;
      return s;
   endfunction

   function automatic logic [31:0] mkInst(input logic [4:0] msb, input logic [4:0] lsb, input logic [5:0] fn);
      return {6'b011111, 5'd1, 5'd2, msb, lsb, fn};
   endfunction

   task automatic applyStimulus(input stim_t s);
      id_valid = s.v; id_inst = s.inst;
      id_rs_addr = s.rsA; id_rt_addr = s.rtA; id_rs_data = s.rsD; id_rt_data = s.rtD;
      mem_we = s.mwe; mem_waddr = s.mwa; mem_wdata = s.mwd;
      wb_we = s.wwe; wb_waddr = s.wwa; wb_wdata = s.wwd;
      ex_ready = s.exr; flush = s.fl;
      @(posedge clk);
      #2;
   endtask

   function automatic stim_t randStim();
      stim_t s;
      logic [31:0] w;
      int pick;
      s = idleStim();
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:26] = 6'b011111;
      pick = $urandom_range(0, 2);
      if (pick == 0) w[5:0] = 6'b000000;
      else if (pick == 1) w[5:0] = 6'b000100;
      s.v = ($urandom_range(0, 3) != 0);
      s.inst = w;
      s.rsA = 5'($urandom_range(0, 3)); s.rtA = 5'($urandom_range(0, 3));
      s.rsD = $urandom; s.rtD = $urandom;
      s.mwe = 1'($urandom); s.mwa = 5'($urandom_range(0, 3)); s.mwd = $urandom;
      s.wwe = 1'($urandom); s.wwa = 5'($urandom_range(0, 3)); s.wwd = $urandom;
      s.exr = ($urandom_range(0, 2) != 0);
      s.fl = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   initial begin
      stim_t s;
      logic [31:0] held;
      rst = 1'b1;
      applyStimulus(idleStim());
      applyStimulus(idleStim());
      rst = 1'b0;
      checkEn = 1'b1;
      #1;
      checkOutput("reset_valid", 32'(ex_valid), 32'd0);
      checkOutput("reset_ready", 32'(id_ready), 32'd1);
      checkOutput("reset_op1", ex_op1, 32'd0);

      $display("[TB] back-to-back EXT");
      for (int i = 0; i < 3; i++) begin
         s = idleStim();
         s.v = 1; s.inst = mkInst(5'd7, 5'd4, 6'd0) | (32'(i) << 16);
         applyStimulus(s);
         checkOutput("b2b_inst", ex_inst, s.inst);
         checkOutput("b2b_valid", 32'(ex_valid), 32'd1);
         checkOutput("b2b_lsb", 32'(ex_lsb), 32'd4);
         checkOutput("b2b_size", 32'(ex_size_m1), 32'd7);
      end

      $display("[TB] forwarding priority");
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd7, 5'd4, 6'd0);
      s.rsA = 5; s.rsD = 32'h1;
      s.mwe = 1; s.mwa = 5; s.mwd = 32'hAAAA;
      s.wwe = 1; s.wwa = 5; s.wwd = 32'hBBBB;
      applyStimulus(s);
      checkOutput("fwd_mem_over_wb", ex_op1, 32'hAAAA);
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd3, 5'd1, 6'd0);
      s.rsA = 0; s.rsD = 32'h55;
      s.mwe = 1; s.mwa = 0; s.mwd = 32'hFFFF;
      applyStimulus(s);
      checkOutput("fwd_r0", ex_op1, 32'h55);

      $display("[TB] stall snoop");
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd9, 5'd2, 6'd4); s.rtA = 9; s.rtD = 32'h77;
      applyStimulus(s);
      held = s.inst;
      for (int c = 1; c <= 3; c++) begin
         s = idleStim();
         s.v = 1; s.inst = 32'h1234_5678; s.exr = 0;
         if (c == 2) begin s.wwe = 1; s.wwa = 9; s.wwd = 32'h1234; end
         applyStimulus(s);
         checkOutput("stall_ready", 32'(id_ready), 32'd0);
         checkOutput("stall_inst", ex_inst, held);
         checkOutput("stall_op2", ex_op2, (c == 1) ? 32'h77 : 32'h1234);
      end

      $display("[TB] flush beats capture");
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd5, 5'd5, 6'd0); s.fl = 1;
      applyStimulus(s);
      checkOutput("flush_valid", 32'(ex_valid), 32'd0);
      checkOutput("flush_inst", ex_inst, held);

      $display("[TB] bitfield range");
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd3, 5'd8, 6'd4);
      applyStimulus(s);
      checkOutput("ins_size", 32'(ex_size_m1), 32'd27);
`ifdef BITFIELD_CHECK_EN
      checkOutput("ins_bad", 32'(ex_field_bad), 32'd1);
`else
      checkOutput("ins_bad", 32'(ex_field_bad), 32'd0);
`endif
      s.inst = mkInst(5'd3, 5'd30, 6'd0);
      applyStimulus(s);
`ifdef BITFIELD_CHECK_EN
      checkOutput("ext_bad", 32'(ex_field_bad), 32'd1);
`else
      checkOutput("ext_bad", 32'(ex_field_bad), 32'd0);
`endif
      s.inst = mkInst(5'd3, 5'd28, 6'd0);
      applyStimulus(s);
      checkOutput("ext_ok", 32'(ex_field_bad), 32'd0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++)
         applyStimulus(randStim());

      $display("[TB] reset mid-stream");
      s = idleStim();
      s.v = 1; s.inst = mkInst(5'd1, 5'd1, 6'd0); s.rsA = 7; s.rsD = 32'hDEAD;
      applyStimulus(s);
      checkOutput("pre_reset_op1", ex_op1, 32'hDEAD);
      s = idleStim();
      s.exr = 0;
      applyStimulus(s);
      rst = 1'b1;
      #1;
      checkOutput("async_valid", 32'(ex_valid), 32'd0);
      checkOutput("async_op1", ex_op1, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("post_reset_ready", 32'(id_ready), 32'd1);
      applyStimulus(idleStim());

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
